noc_injector: RTL and testbench
===============================

# noc_injector

Network-interface injection stage sitting directly upstream of the `noc` router's left port. Accepts packets from a local core over a valid/ready handshake, buffers them in a small FIFO, and drives the router's `left_in`/`left_en` inputs with one single-cycle strobe per packet. A programmable inter-packet gap paces injection, since the router port has no backpressure. When idle, the block drives defined zeros, never `z`.

## Interface

Parameters:
- `PACKET_SIZE`, default 8: packet width in bits; matches the router.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `GAP`, default 1: idle cycles forced between consecutive `left_en` pulses; range 0..15.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset. Asserting it low clears all state immediately.
- `core_data`, in, PACKET_SIZE: packet from the local core.
- `core_valid`, in, 1: `core_data` is valid this cycle.
- `core_ready`, out, 1: the FIFO can accept a packet; computed as `level != DEPTH`.
- `hold`, in, 1: when high, injection is suspended; the FIFO still accepts packets.
- `left_in`, out, PACKET_SIZE: registered packet to the router left port. It is 0 whenever `left_en` is 0.
- `left_en`, out, 1: registered strobe, high for exactly one cycle per packet.
- `level`, out, clog2(DEPTH)+1: current FIFO occupancy.

## Operation

- **Push:** occurs on a rising edge when `core_valid && core_ready`. Packets are stored in FIFO order.
- **States:** the controller has two states, IDLE and GAP. Reset enters IDLE.
- **IDLE, packet available:** when `level != 0 && !hold`, the next edge does all of the following:
  - pops the FIFO head;
  - registers it into `left_in` and sets `left_en = 1`;
  - if `GAP > 0`, loads `gap_cnt = GAP` and moves to GAP;
  - if `GAP == 0`, stays in IDLE, which allows back-to-back pulses.
- **IDLE, nothing to send:** otherwise the next edge sets `left_en = 0` and `left_in = 0`.
- **GAP state:**
  - `left_en = 0` and `left_in = 0`.
  - `gap_cnt` decrements on each edge.
  - On the edge where `gap_cnt == 1`, the controller moves to IDLE.
  - `hold` has no effect while in GAP.
- **Simultaneous push and pop:** allowed in the same cycle. `level` stays unchanged and ordering is preserved.
- **Full FIFO:** `core_ready` is low and no push occurs, even if a pop happens in that same cycle. `core_ready` is derived from registered `level`, so there is no combinational path from the pop.
- **Empty FIFO:** no pop and no strobe. A pop is never issued while `level == 0`.
- **Wrap-around:** read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. `level` is tracked separately, so full and empty are unambiguous.
- **Reset:**
  - All outputs return to reset values: `left_en = 0`, `left_in = 0`, `level = 0`, `core_ready = 1`.
  - Pointers and `gap_cnt` are cleared and the state returns to IDLE.
  - FIFO contents are discarded.
  - A reset asserted mid-burst drops every queued packet. No strobe is emitted after reset is released until a new push occurs.

## Timing

- **Latency:** a packet pushed at edge N into an empty FIFO, with `hold = 0` and the controller in IDLE, appears with `left_en = 1` after edge N+1. That is one edge of latency; there is no bypass path.
- **Pulse spacing:** consecutive strobes are exactly GAP+1 cycles apart while the FIFO is non-empty and `hold` is low.
- **Throughput:** peak throughput is 1/(GAP+1) packets per cycle.
- **Hold:** `hold` is sampled only in IDLE. Raising `hold` at edge M means no strobe after edge M. Dropping `hold` in the cycle before edge K gives a strobe after edge K, provided the FIFO is non-empty.
- **Output registers:** `left_in` and `left_en` are driven from flops only.

## Structure

- Shared package `noc_pkg` holds:
  - `PACKET_SIZE` default;
  - the controller state encoding (IDLE, GAP);
  - a `packet_t` typedef, `logic [PACKET_SIZE-1:0]`.
- One sub-module: `noc_fifo`, a synchronous FIFO with push, pop, data in/out, and `level`, parameterised by `DEPTH` and width. The injector top contains the pacing FSM, the gap counter and the output registers.

## Test plan

- **Reset values:** drive `rst = 0` with `core_valid = 1`. Required: `left_en = 0`, `left_in = 8'h00`, `level = 0`, `core_ready = 1`, and no push.
- **Single packet:** push `8'h03` at edge N (`GAP = 1`). Required: `left_in = 8'h03` and `left_en = 1` for exactly the cycle after edge N+1; `level` returns to 0; `left_in = 0` afterwards.
- **Burst into full FIFO:** push `8'hA1`..`8'hA5` on consecutive edges (`DEPTH = 4`, `GAP = 2`). Required: `core_ready` deasserts once `level = 4`, so `8'hA5` is held by the source until it is accepted. Strobes come out in order A1..A5 and are spaced exactly 3 cycles apart.
- **Hold:** queue `8'h10` and `8'h20` with `hold = 1` for 5 cycles. Required: no `left_en` and `level = 2`. After `hold` drops, `8'h10` strobes after the next edge and `8'h20` strobes GAP+1 cycles later.
- **Back-to-back:** set `GAP = 0` and push `8'h01`, `8'h02`, `8'h03` back-to-back. Required: `left_en` high for 3 consecutive cycles carrying 01, 02, 03, with push and pop in the same cycles and `level` never exceeding 2.
- **Reset mid-burst:** with `level = 3`, pull `rst` low for 1 cycle mid-GAP. Required: `left_en` is immediately 0 and `level` is 0, and no strobes follow reset release until a new push.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC injection path.
package noc_pkg;

   localparam int unsigned PACKET_SIZE_DEFAULT = 8;
   localparam int unsigned GAP_W               = 4;

   typedef logic [PACKET_SIZE_DEFAULT-1:0] packet_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } inj_state_t;

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with explicit occupancy count; pointers wrap modulo DEPTH.
module noc_fifo
   import noc_pkg::*;
#(
   parameter int unsigned WIDTH = PACKET_SIZE_DEFAULT,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // Refuse writes when full and reads when empty, independent of the caller.
   assign do_push = push && (count != FULL);
   assign do_pop  = pop && (count != '0);

   assign dout  = mem[rd_ptr];
   assign level = count;

   // Storage array; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/noc_injector.sv
// Paces packets from a local core into the router left port, one strobe per packet.
module noc_injector
   import noc_pkg::*;
#(
   parameter int unsigned PACKET_SIZE = PACKET_SIZE_DEFAULT,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned GAP         = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PACKET_SIZE-1:0] core_data,
   input  logic                   core_valid,
   output logic                   core_ready,
   input  logic                   hold,
   output logic [PACKET_SIZE-1:0] left_in,
   output logic                   left_en,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0]    FULL     = LW'(DEPTH);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

   inj_state_t             state;
   logic [GAP_W-1:0]       gap_cnt;
   logic [PACKET_SIZE-1:0] head;
   logic                   push;
   logic                   pop;

   // Ready comes from the registered level only, so a same-cycle pop never frees a slot.
   assign core_ready = (level != FULL);
   assign push       = core_valid && core_ready;
   assign pop        = (state == ST_IDLE) && (level != '0) && !hold;

   noc_fifo #(
      .WIDTH (PACKET_SIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (core_data),
      .dout  (head),
      .level (level)
   );

   // Pacing controller: strobe on pop, then hold off for GAP idle cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         gap_cnt <= '0;
         left_en <= 1'b0;
         left_in <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  left_en <= 1'b1;
                  left_in <= head;
                  if (GAP > 0) begin
                     gap_cnt <= GAP_LOAD;
                     state   <= ST_GAP;
                  end
               end else begin
                  left_en <= 1'b0;
                  left_in <= '0;
               end
            end
            ST_GAP: begin
               left_en <= 1'b0;
               left_in <= '0;
               gap_cnt <= gap_cnt - GAP_W'(1);
               if (gap_cnt == GAP_W'(1)) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               left_en <= 1'b0;
               left_in <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_noc_injector.sv
// Bench for noc_injector: three instances (GAP 0, 1, 2) against a schedule-based model.
module tb_noc_injector;

   localparam int NI    = 3;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] core_data  [NI];
   logic       core_valid [NI];
   logic       core_ready [NI];
   logic       hold       [NI];
   logic [7:0] left_in    [NI];
   logic       left_en    [NI];
   logic [2:0] level      [NI];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_dut
      noc_injector #(
         .PACKET_SIZE (8),
         .DEPTH       (DEPTH),
         .GAP         (g)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .core_data  (core_data[g]),
         .core_valid (core_valid[g]),
         .core_ready (core_ready[g]),
         .hold       (hold[g]),
         .left_in    (left_in[g]),
         .left_en    (left_en[g]),
         .level      (level[g])
      );

      // Model: a packet leaves when queued, not held, and the earliest allowed time has come.
      logic [7:0] q[$];
      int         mcyc    = 0;
      int         next_ok = 0;
      logic       exp_en  = 1'b0;
      logic [7:0] exp_in  = 8'h00;
      bit         can_push;

      always @(posedge clk or negedge rst) begin
         if (!rst) begin
            q.delete();
            next_ok = 0;
            exp_en  = 1'b0;
            exp_in  = 8'h00;
         end else begin
            can_push = (q.size() != DEPTH);
            if (mcyc >= next_ok && q.size() != 0 && !hold[g]) begin
               exp_en  = 1'b1;
               exp_in  = q.pop_front();
               next_ok = mcyc + g + 1;
            end else begin
               exp_en = 1'b0;
               exp_in = 8'h00;
            end
            if (core_valid[g] && can_push) q.push_back(core_data[g]);
         end
         mcyc++;
      end

      // Per-cycle comparison plus a strobe log for the directed sequences.
      int         ncnt   = 0;
      int         maxlvl = 0;
      int         log_t[$];
      logic [7:0] log_d[$];

      always @(negedge clk) begin
         check_eq($sformatf("g%0d_left_en", g),    32'(left_en[g]),    32'(exp_en));
         check_eq($sformatf("g%0d_left_in", g),    32'(left_in[g]),    32'(exp_in));
         check_eq($sformatf("g%0d_level", g),      32'(level[g]),      32'(q.size()));
         check_eq($sformatf("g%0d_core_ready", g), 32'(core_ready[g]), 32'(q.size() != DEPTH));
         if (left_en[g]) begin
            log_t.push_back(ncnt);
            log_d.push_back(left_in[g]);
         end
         if (int'(level[g]) > maxlvl) maxlvl = int'(level[g]);
         ncnt++;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Present a packet and wait until it is accepted; returns just after the accepting edge.
   task automatic push_pkt(input int i, input logic [7:0] d);
      bit done = 1'b0;
      bit r;
      core_data[i]  = d;
      core_valid[i] = 1'b1;
      for (int k = 0; k < 64 && !done; k++) begin
         r = core_ready[i];
         @(posedge clk);
         if (r) done = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      if (!done) check_eq("push_timeout", 32'(done), 32'(1));
   endtask

   initial begin
      #2_000_000;
      check_eq("watchdog", 32'(0), 32'(1));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      for (int i = 0; i < NI; i++) begin
         core_data[i]  = 8'h55;
         core_valid[i] = 1'b1;
         hold[i]       = 1'b0;
      end
      #1 rst = 1'b0;

      // Reset with valid asserted: nothing is pushed, outputs at reset values.
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check_eq("rst_left_en", 32'(left_en[i]), 32'(0));
         check_eq("rst_left_in", 32'(left_in[i]), 32'(0));
         check_eq("rst_level", 32'(level[i]), 32'(0));
         check_eq("rst_core_ready", 32'(core_ready[i]), 32'(1));
      end
      #1;
      rst = 1'b1;
      for (int i = 0; i < NI; i++) core_valid[i] = 1'b0;
      repeat (2) tick();

      // Single packet on GAP=1: strobe one edge after the push edge.
      push_pkt(1, 8'h03);
      @(negedge clk);
      check_eq("single_not_yet", 32'(left_en[1]), 32'(0));
      check_eq("single_level1", 32'(level[1]), 32'(1));
      #1 core_valid[1] = 1'b0;
      @(negedge clk);
      check_eq("single_en", 32'(left_en[1]), 32'(1));
      check_eq("single_data", 32'(left_in[1]), 32'(8'h03));
      check_eq("single_level0", 32'(level[1]), 32'(0));
      @(negedge clk);
      check_eq("single_en_after", 32'(left_en[1]), 32'(0));
      check_eq("single_in_after", 32'(left_in[1]), 32'(0));
      #1;
      repeat (3) tick();

      // Burst into a full FIFO on GAP=2; hold fills it so A5 must wait.
      g_dut[2].log_t.delete();
      g_dut[2].log_d.delete();
      hold[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_pkt(2, 8'hA1 + 8'(k));
         tick();
      end
      core_valid[2] = 1'b0;
      @(negedge clk);
      check_eq("burst_level_full", 32'(level[2]), 32'(4));
      check_eq("burst_ready_low", 32'(core_ready[2]), 32'(0));
      #1;
      hold[2] = 1'b0;
      push_pkt(2, 8'hA5);
      tick();
      core_valid[2] = 1'b0;
      repeat (20) tick();
      check_eq("burst_count", 32'(g_dut[2].log_d.size()), 32'(5));
      if (g_dut[2].log_d.size() == 5) begin
         for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("burst_data%0d", k), 32'(g_dut[2].log_d[k]), 32'(8'hA1 + 8'(k)));
         end
         for (int k = 1; k < 5; k++) begin
            check_eq($sformatf("burst_space%0d", k),
                     32'(g_dut[2].log_t[k] - g_dut[2].log_t[k-1]), 32'(3));
         end
      end

      // Hold on GAP=1: two packets wait, then leave GAP+1 cycles apart.
      hold[1] = 1'b1;
      push_pkt(1, 8'h10);
      tick();
      push_pkt(1, 8'h20);
      tick();
      core_valid[1] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq("hold_no_en", 32'(left_en[1]), 32'(0));
      end
      check_eq("hold_level", 32'(level[1]), 32'(2));
      #1 hold[1] = 1'b0;
      @(negedge clk);
      check_eq("hold_first_en", 32'(left_en[1]), 32'(1));
      check_eq("hold_first_data", 32'(left_in[1]), 32'(8'h10));
      @(negedge clk);
      check_eq("hold_gap", 32'(left_en[1]), 32'(0));
      @(negedge clk);
      check_eq("hold_second_en", 32'(left_en[1]), 32'(1));
      check_eq("hold_second_data", 32'(left_in[1]), 32'(8'h20));
      #1;
      repeat (3) tick();

      // Back-to-back on GAP=0.
      g_dut[0].log_t.delete();
      g_dut[0].log_d.delete();
      g_dut[0].maxlvl = 0;
      for (int k = 0; k < 3; k++) begin
         push_pkt(0, 8'h01 + 8'(k));
         tick();
      end
      core_valid[0] = 1'b0;
      repeat (5) tick();
      check_eq("b2b_count", 32'(g_dut[0].log_d.size()), 32'(3));
      if (g_dut[0].log_d.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("b2b_data%0d", k), 32'(g_dut[0].log_d[k]), 32'(8'h01 + 8'(k)));
         end
         for (int k = 1; k < 3; k++) begin
            check_eq($sformatf("b2b_space%0d", k),
                     32'(g_dut[0].log_t[k] - g_dut[0].log_t[k-1]), 32'(1));
         end
      end
      check_eq("b2b_maxlevel_le2", 32'(g_dut[0].maxlvl <= 2), 32'(1));

      // Reset mid-GAP with packets queued drops everything.
      hold[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         push_pkt(2, 8'hB1 + 8'(k));
         tick();
      end
      core_valid[2] = 1'b0;
      @(negedge clk);
      check_eq("midrst_level3", 32'(level[2]), 32'(3));
      #1 hold[2] = 1'b0;
      @(negedge clk);
      check_eq("midrst_strobe", 32'(left_en[2]), 32'(1));
      #1 rst = 1'b0;
      #1;
      check_eq("midrst_en_async", 32'(left_en[2]), 32'(0));
      check_eq("midrst_in_async", 32'(left_in[2]), 32'(0));
      check_eq("midrst_level_async", 32'(level[2]), 32'(0));
      tick();
      rst = 1'b1;
      g_dut[2].log_d.delete();
      g_dut[2].log_t.delete();
      repeat (8) tick();
      check_eq("midrst_no_strobe", 32'(g_dut[2].log_d.size()), 32'(0));

      // Randomized traffic, hold toggling and occasional reset pulses on all instances.
      for (int c = 0; c < 1500; c++) begin
         tick();
         if (!rst) rst = 1'b1;
         else if ($urandom_range(0, 249) == 0) rst = 1'b0;
         for (int i = 0; i < NI; i++) begin
            core_valid[i] = ($urandom_range(0, 99) < 55);
            core_data[i]  = 8'($urandom);
            if ($urandom_range(0, 9) == 0) hold[i] = ~hold[i];
         end
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         core_valid[i] = 1'b0;
         hold[i]       = 1'b0;
      end
      repeat (20) tick();
      for (int i = 0; i < NI; i++) begin
         check_eq("drain_level", 32'(level[i]), 32'(0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
